// File: rtl/perf_counter_unit.sv
// Performance counter block: cycle, retired-instruction, stall and branch event counters
// under an IDLE/RUN/FROZEN FSM, with a ready/ack snapshot port. Define PERF_SATURATE_EN to saturate.
module perf_counter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             freeze,
    input  logic             clear,
    input  logic             retire_valid,
    input  logic             pipe_stall,
    input  logic             icache_stall,
    input  logic             branch_valid,
    input  logic             branch_mispredict,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic [WIDTH-1:0] cycle_count,
    output logic [WIDTH-1:0] instruction_count,
    output logic [WIDTH-1:0] stall_count,
    output logic [WIDTH-1:0] branch_count,
    output logic [WIDTH-1:0] branch_mispredicts,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_cycle,
    output logic [WIDTH-1:0] snap_instr,
    output logic [WIDTH-1:0] snap_stall,
    output logic [WIDTH-1:0] snap_branch,
    output logic [WIDTH-1:0] snap_mispred,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state_q;
    logic   snap_load;

    assign state = state_q;

    // A full counter holds its value when saturation is enabled instead of wrapping to zero.
    function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] value);
`ifdef PERF_SATURATE_EN
        bump = (&value) ? value : value + ONE;
`else
        bump = value + ONE;
`endif
    endfunction

    // clear outranks freeze, which outranks start; counting is keyed on the current state,
    // so the start cycle is not counted while the freeze cycle is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            cycle_count        <= '0;
            instruction_count  <= '0;
            stall_count        <= '0;
            branch_count       <= '0;
            branch_mispredicts <= '0;
        end else if (clear) begin
            state_q            <= IDLE;
            cycle_count        <= '0;
            instruction_count  <= '0;
            stall_count        <= '0;
            branch_count       <= '0;
            branch_mispredicts <= '0;
        end else begin
            case (state_q)
                IDLE:    if (start)  state_q <= RUN;
                RUN:     if (freeze) state_q <= FROZEN;
                FROZEN:  if (start)  state_q <= RUN;
                default: state_q <= IDLE;
            endcase
            if (state_q == RUN) begin
                cycle_count <= bump(cycle_count);
                if (retire_valid)
                    instruction_count <= bump(instruction_count);
                if (pipe_stall || icache_stall)
                    stall_count <= bump(stall_count);
                if (branch_valid)
                    branch_count <= bump(branch_count);
                if (branch_valid && branch_mispredict)
                    branch_mispredicts <= bump(branch_mispredicts);
            end
        end
    end

    // A new snapshot may overwrite only an empty buffer or one being acknowledged this cycle.
    assign snap_load = snap_req && (!snap_valid || snap_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_valid   <= 1'b0;
            snap_cycle   <= '0;
            snap_instr   <= '0;
            snap_stall   <= '0;
            snap_branch  <= '0;
            snap_mispred <= '0;
        end else if (snap_load) begin
            snap_valid   <= 1'b1;
            snap_cycle   <= cycle_count;
            snap_instr   <= instruction_count;
            snap_stall   <= stall_count;
            snap_branch  <= branch_count;
            snap_mispred <= branch_mispredicts;
        end else if (snap_ack) begin
            snap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit: a 32-bit instance for the main
// sequence and a 4-bit instance for wrap/saturation (follows PERF_SATURATE_EN).
module tb_perf_counter_unit;

    logic clk;
    logic reset;
    logic start, freeze, clear, retire_valid, pipe_stall, icache_stall;
    logic branch_valid, branch_mispredict, snap_req, snap_ack;
    logic [31:0] cycle_count, instruction_count, stall_count, branch_count, branch_mispredicts;
    logic        snap_valid;
    logic [31:0] snap_cycle, snap_instr, snap_stall, snap_branch, snap_mispred;
    logic [1:0]  state;

    logic       start4;
    logic [3:0] cycle4, instr4, stall4, branch4, mispred4;
    logic       snap_valid4;
    logic [3:0] snap_cycle4, snap_instr4, snap_stall4, snap_branch4, snap_mispred4;
    logic [1:0] state4;

    int compared   = 0;
    int mismatched = 0;

`ifdef PERF_SATURATE_EN
    localparam logic [31:0] NARROW_EXPECT = 32'd15;
`else
    localparam logic [31:0] NARROW_EXPECT = 32'd4;
`endif

    perf_counter_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .freeze(freeze), .clear(clear),
        .retire_valid(retire_valid), .pipe_stall(pipe_stall), .icache_stall(icache_stall),
        .branch_valid(branch_valid), .branch_mispredict(branch_mispredict),
        .snap_req(snap_req), .snap_ack(snap_ack),
        .cycle_count(cycle_count), .instruction_count(instruction_count),
        .stall_count(stall_count), .branch_count(branch_count),
        .branch_mispredicts(branch_mispredicts), .snap_valid(snap_valid),
        .snap_cycle(snap_cycle), .snap_instr(snap_instr), .snap_stall(snap_stall),
        .snap_branch(snap_branch), .snap_mispred(snap_mispred), .state(state)
    );

    perf_counter_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .freeze(1'b0), .clear(1'b0),
        .retire_valid(1'b1), .pipe_stall(1'b0), .icache_stall(1'b0),
        .branch_valid(1'b0), .branch_mispredict(1'b0),
        .snap_req(1'b0), .snap_ack(1'b0),
        .cycle_count(cycle4), .instruction_count(instr4),
        .stall_count(stall4), .branch_count(branch4),
        .branch_mispredicts(mispred4), .snap_valid(snap_valid4),
        .snap_cycle(snap_cycle4), .snap_instr(snap_instr4), .snap_stall(snap_stall4),
        .snap_branch(snap_branch4), .snap_mispred(snap_mispred4), .state(state4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, let the edge happen, then return all pulses to zero.
    task automatic applyStimulus(input logic st, input logic fr, input logic cl,
                                 input logic rv, input logic ps, input logic is,
                                 input logic bv, input logic bm,
                                 input logic sr, input logic sa);
        start = st; freeze = fr; clear = cl; retire_valid = rv;
        pipe_stall = ps; icache_stall = is; branch_valid = bv; branch_mispredict = bm;
        snap_req = sr; snap_ack = sa;
        tick();
        start = 0; freeze = 0; clear = 0; retire_valid = 0;
        pipe_stall = 0; icache_stall = 0; branch_valid = 0; branch_mispredict = 0;
        snap_req = 0; snap_ack = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1; start4 = 0;
        start = 0; freeze = 0; clear = 0; retire_valid = 0;
        pipe_stall = 0; icache_stall = 0; branch_valid = 0; branch_mispredict = 0;
        snap_req = 0; snap_ack = 0;
        #2 reset = 0;
        #10;
        $display("[TB] reset state");
        checkOutput("reset_state", {30'd0, state}, 32'd0);
        checkOutput("reset_cycle", cycle_count, 32'd0);
        checkOutput("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
        tick();
        reset = 1;
        tick();

        $display("[TB] narrow counter wrap/saturate");
        start4 = 1; tick(); start4 = 0;
        repeat (20) tick();
        checkOutput("narrow_cycle", {28'd0, cycle4}, NARROW_EXPECT);
        checkOutput("narrow_instr", {28'd0, instr4}, NARROW_EXPECT);

        $display("[TB] start, 10 retire cycles, freeze");
        applyStimulus(1,0,0, 0,0,0, 0,0, 0,0);
        checkOutput("start_state", {30'd0, state}, 32'd1);
        checkOutput("start_cycle_not_counted", cycle_count, 32'd0);
        for (int i = 0; i < 9; i++) applyStimulus(0,0,0, 1,0,0, 0,0, 0,0);
        applyStimulus(0,1,0, 1,0,0, 0,0, 0,0);
        checkOutput("freeze_cycle", cycle_count, 32'd10);
        checkOutput("freeze_instr", instruction_count, 32'd10);
        checkOutput("freeze_state", {30'd0, state}, 32'd2);

        $display("[TB] frozen ignores events");
        for (int i = 0; i < 3; i++) applyStimulus(0,0,0, 1,1,0, 1,1, 0,0);
        checkOutput("frozen_cycle", cycle_count, 32'd10);
        checkOutput("frozen_instr", instruction_count, 32'd10);
        checkOutput("frozen_branch", branch_count, 32'd0);

        $display("[TB] resume and stalls");
        applyStimulus(1,0,0, 0,0,0, 0,0, 0,0);
        checkOutput("resume_state", {30'd0, state}, 32'd1);
        checkOutput("resume_cycle", cycle_count, 32'd10);
        for (int i = 0; i < 4; i++) applyStimulus(0,0,0, 0,1,1, 0,0, 0,0);
        checkOutput("dual_stall", stall_count, 32'd4);
        applyStimulus(0,0,0, 0,1,0, 0,0, 0,0);
        applyStimulus(0,0,0, 0,0,1, 0,0, 0,0);
        checkOutput("single_stalls", stall_count, 32'd6);
        checkOutput("stall_cycle", cycle_count, 32'd16);

        $display("[TB] branches");
        for (int i = 0; i < 6; i++)
            applyStimulus(0,0,0, 0,0,0, 1,(i == 1 || i == 4), 0,0);
        applyStimulus(0,0,0, 0,0,0, 0,1, 0,0);
        checkOutput("branch_count", branch_count, 32'd6);
        checkOutput("branch_mispredicts", branch_mispredicts, 32'd2);
        checkOutput("branch_cycle", cycle_count, 32'd23);
        checkOutput("branch_instr", instruction_count, 32'd10);

        $display("[TB] clear with retire and freeze");
        applyStimulus(0,1,1, 1,0,0, 0,0, 0,0);
        checkOutput("clear_state", {30'd0, state}, 32'd0);
        checkOutput("clear_cycle", cycle_count, 32'd0);
        checkOutput("clear_instr", instruction_count, 32'd0);
        checkOutput("clear_stall", stall_count, 32'd0);
        checkOutput("clear_branch", branch_count, 32'd0);
        checkOutput("clear_mispred", branch_mispredicts, 32'd0);

        $display("[TB] snapshot handshake");
        applyStimulus(1,0,0, 0,0,0, 0,0, 0,0);
        for (int i = 0; i < 20; i++) applyStimulus(0,0,0, 0,0,0, 0,0, 0,0);
        checkOutput("pre_snap_cycle", cycle_count, 32'd20);
        applyStimulus(0,0,0, 0,0,0, 0,0, 1,0);
        checkOutput("snap1_valid", {31'd0, snap_valid}, 32'd1);
        checkOutput("snap1_cycle", snap_cycle, 32'd20);
        checkOutput("snap1_instr", snap_instr, 32'd0);
        applyStimulus(0,0,0, 0,0,0, 0,0, 0,0);
        applyStimulus(0,0,0, 0,0,0, 0,0, 0,0);
        applyStimulus(0,0,0, 0,0,0, 0,0, 1,0);
        checkOutput("snap_drop_cycle", snap_cycle, 32'd20);
        checkOutput("snap_drop_valid", {31'd0, snap_valid}, 32'd1);
        applyStimulus(0,0,0, 0,0,0, 0,0, 1,1);
        checkOutput("snap_reload_valid", {31'd0, snap_valid}, 32'd1);
        checkOutput("snap_reload_cycle", snap_cycle, 32'd24);
        applyStimulus(0,0,0, 0,0,0, 0,0, 0,1);
        checkOutput("ack_valid", {31'd0, snap_valid}, 32'd0);
        checkOutput("ack_cycle_retained", snap_cycle, 32'd24);
        applyStimulus(0,0,0, 0,0,0, 0,0, 1,0);
        checkOutput("snap3_cycle", snap_cycle, 32'd26);
        checkOutput("live_cycle", cycle_count, 32'd27);

        $display("[TB] clear leaves snapshot alone");
        applyStimulus(0,0,1, 0,0,0, 0,0, 0,0);
        checkOutput("clear_keeps_snap_valid", {31'd0, snap_valid}, 32'd1);
        checkOutput("clear_keeps_snap_cycle", snap_cycle, 32'd26);
        checkOutput("clear2_cycle", cycle_count, 32'd0);

        $display("[TB] async reset during RUN");
        applyStimulus(1,0,0, 0,0,0, 0,0, 0,0);
        applyStimulus(0,0,0, 1,0,0, 0,0, 0,0);
        applyStimulus(0,0,0, 1,0,0, 0,0, 0,0);
        checkOutput("prereset_instr", instruction_count, 32'd2);
        reset = 0;
        #2;
        checkOutput("async_state", {30'd0, state}, 32'd0);
        checkOutput("async_cycle", cycle_count, 32'd0);
        checkOutput("async_instr", instruction_count, 32'd0);
        checkOutput("async_snap_valid", {31'd0, snap_valid}, 32'd0);
        checkOutput("async_snap_cycle", snap_cycle, 32'd0);
        tick();
        reset = 1;
        for (int i = 0; i < 3; i++) applyStimulus(0,0,0, 1,0,0, 0,0, 0,0);
        checkOutput("post_reset_idle", {30'd0, state}, 32'd0);
        checkOutput("post_reset_cycle", cycle_count, 32'd0);
        checkOutput("post_reset_instr", instruction_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 Parameter: WIDTH, 32, bit width of every event counter and snapshot register.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: start  input  1  single-cycle pulse; enter or resume counting.
REQ-005 Port: freeze  input  1  single-cycle pulse; stop counting and hold values.
REQ-006 Port: clear  input  1  synchronous zeroing of all counters; return to IDLE.
REQ-007 Port: retire_valid  input  1  one instruction retired at writeback this cycle.
REQ-008 Port: pipe_stall  input  1  pipeline stall (hazard) this cycle.
REQ-009 Port: icache_stall  input  1  fetch stall from the instruction cache this cycle.
REQ-010 Port: branch_valid  input  1  a branch resolved in EX this cycle.
REQ-011 Port: branch_mispredict  input  1  the resolved branch was mispredicted; qualified by branch_valid.
REQ-012 Port: snap_req  input  1  request to capture all counters.
REQ-013 Port: snap_ack  input  1  consumer accepted the snapshot.
REQ-014 Port: cycle_count, instruction_count, stall_count, branch_count, branch_mispredicts  output  WIDTH each  live counters.
REQ-015 Port: snap_valid  output  1  snapshot registers hold unconsumed data.
REQ-016 Port: snap_cycle, snap_instr, snap_stall, snap_branch, snap_mispred  output  WIDTH each  captured values.
REQ-017 Port: state  output  2  FSM state: 0 IDLE, 1 RUN, 2 FROZEN.

Function
REQ-018 FSM transitions: IDLE->RUN on start; RUN->FROZEN on freeze; FROZEN->RUN on start; any state->IDLE on clear.
REQ-019 Priority when pulses coincide: clear > freeze > start.
REQ-020 In RUN: cycle_count +1 every cycle; instruction_count +1 per retire_valid; stall_count +1 per cycle with (pipe_stall | icache_stall), at most once per cycle.
REQ-021 In RUN: branch_count +1 per branch_valid; branch_mispredicts +1 only when branch_valid & branch_mispredict; a mispredict without branch_valid is ignored.
REQ-022 In IDLE and FROZEN, all counters hold; events are ignored.
REQ-023 Counters are registered; an event in cycle N is visible on outputs in cycle N+1.
REQ-024 The cycle in which start is sampled in IDLE/FROZEN is not counted; the cycle in which freeze is sampled in RUN is counted.
REQ-025 clear zeroes all five counters at the next edge, regardless of same-cycle events or state.
REQ-026 Snapshot: when snap_req=1 and (snap_valid=0 or snap_ack=1), the five snap_* registers load the live counter values present on the outputs in that cycle, and snap_valid=1 the next cycle.
REQ-027 snap_req while snap_valid=1 without snap_ack is dropped; snap_* unchanged.
REQ-028 snap_ack with snap_valid=1 and no snap_req clears snap_valid next cycle; snap_* retain last values.
REQ-029 Snapshot logic operates in all FSM states; clear does not affect snap_valid or snap_*.
REQ-030 Invariants: branch_mispredicts <= branch_count; stall_count <= cycle_count.

Reset
REQ-031 On reset=0, asynchronously: state=IDLE, all counters=0, snap_valid=0, all snap_*=0.
REQ-032 Reset asserted mid-count or mid-handshake discards all state; after release the block is in IDLE and needs start to count.

Configuration
REQ-033 Macro PERF_SATURATE_EN: when defined, every counter saturates at 2^WIDTH-1 and holds; when undefined, counters wrap modulo 2^WIDTH.
REQ-034 With PERF_SATURATE_EN, REQ-030 holds at all times; without it, REQ-030 holds only until the first wrap.

Verification
REQ-035 Reset, start, 10 cycles with retire_valid=1 each cycle, freeze -> cycle_count=10 (start cycle excluded, freeze cycle included), instruction_count=10, state=2.
REQ-036 In RUN, pipe_stall=1 and icache_stall=1 together for 4 cycles -> stall_count +4, not +8.
REQ-037 branch_valid=1 for 6 cycles, branch_mispredict=1 on 2 of them, plus 1 cycle branch_mispredict=1 with branch_valid=0 -> branch_count=6, branch_mispredicts=2.
REQ-038 snap_req at cycle_count=20, second snap_req 3 cycles later without ack -> snap_cycle=20 and unchanged; snap_ack together with snap_req -> snap_valid stays 1, snap_cycle updates to the current value.
REQ-039 clear in the same cycle as retire_valid and freeze -> all counters 0, state=0; reset=0 during RUN with snap_valid=1 -> all outputs 0 immediately.
REQ-040 WIDTH=4, 20 RUN cycles -> cycle_count=15 with PERF_SATURATE_EN, 4 without.
